ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 88 ++++++++
 tb/tb_ram_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for the RAM port arbiter: CPU and readout
// request/grant handshakes, the shared RAM port and the conflict counter.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              readout_mode;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dina;
    logic [DATA_W-1:0] ram_douta;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output rd_req, rd_addr, readout_mode, ram_douta,
        input  cpu_gnt, cpu_rvalid, rd_gnt, rd_rvalid, rdata,
        input  ram_ena, ram_wea, ram_addra, ram_dina, conflict_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  rd_req, rd_addr, readout_mode, ram_douta,
        output cpu_gnt, cpu_rvalid, rd_gnt, rd_rvalid, rdata,
        output ram_ena, ram_wea, ram_addra, ram_dina, conflict_cnt
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between a CPU and a readout unit.
// One registered command per cycle, alternating winner on conflict.
module ram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              reset,
    ram_port_arbiter_if.slave bus
);
    logic              cpu_elig;
    logic              rd_elig;
    logic              pick_cpu;
    logic              pick_rd;
    logic              last_rd;
    logic              cpu_gnt_q;
    logic              rd_gnt_q;
    logic              cpu_rv_q;
    logic              rd_rv_q;
    logic              ena_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [CNT_W-1:0]  cnt_q;

    // Eligibility and winner selection; a requester granted last
    // cycle sits out one edge, and a tie goes to the one not served last.
    always_comb begin
        cpu_elig = bus.cpu_req && !cpu_gnt_q;
        rd_elig  = bus.rd_req && !rd_gnt_q && bus.readout_mode;
        pick_cpu = cpu_elig && (!rd_elig || last_rd);
        pick_rd  = rd_elig && !pick_cpu;
    end

    // Registered RAM command, grant pulses, read-valid pulses and counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_gnt_q <= 1'b0;
            rd_gnt_q  <= 1'b0;
            cpu_rv_q  <= 1'b0;
            rd_rv_q   <= 1'b0;
            ena_q     <= 1'b0;
            wea_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            last_rd   <= 1'b1;
        end else begin
            cpu_gnt_q <= pick_cpu;
            rd_gnt_q  <= pick_rd;
            ena_q     <= pick_cpu || pick_rd;
            cpu_rv_q  <= cpu_gnt_q && !wea_q;
            rd_rv_q   <= rd_gnt_q;
            if (pick_cpu) begin
                wea_q   <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                din_q   <= bus.cpu_wdata;
                last_rd <= 1'b0;
            end else if (pick_rd) begin
                wea_q   <= 1'b0;
                addr_q  <= bus.rd_addr;
                din_q   <= '0;
                last_rd <= 1'b1;
            end else begin
                wea_q   <= 1'b0;
            end
            if (cpu_elig && rd_elig && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // RAM data is passed through only while a read result is being
    // delivered, so rdata reads as zero out of reset and when idle.
    always_comb begin
        bus.rdata = (cpu_rv_q || rd_rv_q) ? bus.ram_douta : '0;
    end

    assign bus.cpu_gnt      = cpu_gnt_q;
    assign bus.rd_gnt       = rd_gnt_q;
    assign bus.cpu_rvalid   = cpu_rv_q;
    assign bus.rd_rvalid    = rd_rv_q;
    assign bus.ram_ena      = ena_q;
    assign bus.ram_wea      = wea_q;
    assign bus.ram_addra    = addr_q;
    assign bus.ram_dina     = din_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model with shadow RAM.
module tb_ram_port_arbiter;
    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
            else             bus.ram_douta <= mem[bus.ram_addra];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model state: what should be visible after each edge.
    bit            m_cg, m_rg, m_en, m_we, m_crv, m_rrv;
    bit            cpu_served_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_rdata, pend;
    int            m_cnt;
    int            n_conf;
    logic [DW-1:0] sh [0:(1<<AW)-1];

    task automatic model_edge();
        bit ce, re, wc, wr;
        if (!reset) begin
            {m_cg, m_rg, m_en, m_we, m_crv, m_rrv} = '0;
            m_addr = '0;
            m_din  = '0;
            m_cnt  = 0;
            cpu_served_last = 1'b0;
            return;
        end
        ce = bus.cpu_req && !m_cg;
        re = bus.rd_req && bus.readout_mode && !m_rg;
        if (ce && re) begin
            n_conf++;
            if (m_cnt < SAT) m_cnt++;
        end
        wc = ce && (!re || !cpu_served_last);
        wr = re && !wc;
        m_crv   = m_cg && !m_we;
        m_rrv   = m_rg;
        m_rdata = pend;
        if (wc) begin
            m_we   = bus.cpu_we;
            m_addr = bus.cpu_addr;
            m_din  = bus.cpu_wdata;
            cpu_served_last = 1'b1;
            if (bus.cpu_we) sh[bus.cpu_addr] = bus.cpu_wdata;
            else            pend = sh[bus.cpu_addr];
        end else if (wr) begin
            m_we   = 1'b0;
            m_addr = bus.rd_addr;
            m_din  = '0;
            cpu_served_last = 1'b0;
            pend   = sh[bus.rd_addr];
        end else begin
            m_we = 1'b0;
        end
        m_cg = wc;
        m_rg = wr;
        m_en = wc || wr;
    endtask

    task automatic check_outputs();
        chk("cpu_gnt", bus.cpu_gnt, m_cg);
        chk("rd_gnt", bus.rd_gnt, m_rg);
        chk("ram_ena", bus.ram_ena, m_en);
        chk("ram_wea", bus.ram_wea, m_we);
        chk("cpu_rvalid", bus.cpu_rvalid, m_crv);
        chk("rd_rvalid", bus.rd_rvalid, m_rrv);
        chk("rvalid_excl", bus.cpu_rvalid & bus.rd_rvalid, 0);
        chk("conflict_cnt", bus.conflict_cnt, m_cnt);
        if (m_en) begin
            chk("ram_addra", bus.ram_addra, m_addr);
            chk("ram_dina", bus.ram_dina, m_din);
        end
        if (m_crv || m_rrv) chk("rdata", bus.rdata, m_rdata);
    endtask

    // Inputs are set before calling; model predicts the coming edge.
    task automatic tick();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_random();
        if (!bus.cpu_req || m_cg) begin
            bus.cpu_req   = ($urandom_range(0, 2) != 0);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = AW'($urandom_range(0, 7));
            bus.cpu_wdata = DW'($urandom);
        end
        if (!bus.rd_req || m_rg) begin
            bus.rd_req  = ($urandom_range(0, 2) != 0);
            bus.rd_addr = AW'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 15) == 0) bus.readout_mode = ~bus.readout_mode;
        reset = ($urandom_range(0, 199) != 0);
    endtask

    int cnt0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            sh[i]  = '0;
        end
        pend   = '0;
        n_conf = 0;
        reset  = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.readout_mode = 1'b0;
        bus.ram_douta = '0;

        tick();
        tick();
        chk("rst_addra", bus.ram_addra, 0);
        chk("rst_dina", bus.ram_dina, 0);
        chk("rst_rdata", bus.rdata, 0);

        // CPU write then read-back, CPU-only mode.
        reset = 1'b1;
        tick();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 6'h05;
        bus.cpu_wdata = 16'hBEEF;
        tick();
        chk("wr_gnt", bus.cpu_gnt, 1);
        chk("wr_addr", bus.ram_addra, 6'h05);
        chk("wr_data", bus.ram_dina, 16'hBEEF);
        bus.cpu_req = 1'b0;
        tick();
        chk("wr_no_rvalid", bus.cpu_rvalid, 0);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        chk("rd_back_valid", bus.cpu_rvalid, 1);
        chk("rd_back_data", bus.rdata, 16'hBEEF);

        // Readout ignored while mode is 0, served once mode is 1.
        cnt0 = m_cnt;
        bus.rd_req = 1'b1;
        bus.rd_addr = 6'h05;
        for (int i = 0; i < 10; i++) tick();
        chk("mode0_cnt", bus.conflict_cnt, cnt0);
        bus.readout_mode = 1'b1;
        tick();
        chk("mode1_gnt", bus.rd_gnt, 1);
        bus.rd_req = 1'b0;
        tick();
        chk("ro_rdata", bus.rdata, 16'hBEEF);

        // Both held from reset: strict alternation.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.cpu_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("alt_ena", bus.ram_ena, 1);

        // Force conflicts until well past saturation.
        for (int i = 0; i < 3000 && n_conf < 300; i++) begin
            bus.readout_mode = !m_cg && !m_rg;
            tick();
        end
        chk("conf_reached", n_conf >= 300, 1);
        chk("cnt_sat", bus.conflict_cnt, SAT);

        // Reset right after a readout read grant squashes its rvalid.
        bus.cpu_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.readout_mode = 1'b1;
        tick();
        tick();
        bus.rd_req = 1'b1;
        tick();
        chk("pre_rst_gnt", bus.rd_gnt, 1);
        reset = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        chk("rst_no_rvalid", bus.rd_rvalid, 0);
        chk("rst_ena", bus.ram_ena, 0);
        chk("rst_cnt", bus.conflict_cnt, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_gnt", bus.rd_gnt | bus.cpu_gnt, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
